// File: rtl/led_pkg.sv
// Shared types and constants for the LED sequencer: mode/state enums,
// the channel configuration word layout and the reset configuration.
package led_pkg;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_BURST = 2'd3
  } LedModeT;

  typedef enum logic [1:0] {
    S_ON  = 2'd0,
    S_OFF = 2'd1,
    S_GAP = 2'd2
  } BurstStateT;

  typedef struct packed {
    logic [7:0] gap;
    logic [7:0] burst_count;
    logic [7:0] half_period;
    logic [5:0] rsvd;
    LedModeT    mode;
  } LedCfgT;

  localparam int ModeLsb       = 0;
  localparam int HalfPeriodLsb = 8;
  localparam int BurstCountLsb = 16;
  localparam int GapLsb        = 24;

  localparam int NumLedsDef      = 5;
  localparam int PrescWDef       = 24;
  localparam int PrescResetDef   = 1199999;
  localparam int HbHalfPeriodDef = 5;

  // Unused bits are cleared so a stored word reads back masked to its fields.
  function automatic LedCfgT cfg_from_word(input logic [31:0] w);
    LedCfgT c;
    c      = LedCfgT'(w);
    c.rsvd = '0;
    return c;
  endfunction

endpackage

// File: rtl/led_blink_ctrl_if.sv
// Configuration register port of the LED sequencer: write/read strobes,
// address, write data and registered read data.
interface led_blink_ctrl_if #(
  parameter int NumLeds = 5
);
  localparam int AddrW = $clog2(NumLeds + 1);

  logic             cfg_we;
  logic             cfg_re;
  logic [AddrW-1:0] cfg_addr;
  logic [31:0]      cfg_wdata;
  logic [31:0]      cfg_rdata;

  modport master (
    output cfg_we, cfg_re, cfg_addr, cfg_wdata,
    input  cfg_rdata
  );

  modport slave (
    input  cfg_we, cfg_re, cfg_addr, cfg_wdata,
    output cfg_rdata
  );
endinterface

// File: rtl/led_channel.sv
// One LED channel: OFF / ON / BLINK / BURST sequencing, advanced only on
// prescaler ticks; a restart strobe reloads it from the word being written.
module led_channel
  import led_pkg::*;
#(
  parameter logic RstLed = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       restart,
  input  LedModeT    mode,
  input  logic [7:0] half_period,
  input  logic [7:0] burst_count,
  input  logic [7:0] gap,
  input  LedModeT    w_mode,
  input  logic [7:0] w_burst_count,
  output logic       led
);

  BurstStateT st_q, st_n;
  logic [7:0] cnt_q, cnt_n;
  logic [7:0] p_q, p_n;
  logic       led_q, led_n;
  logic [7:0] hp_m1;
  logic [7:0] gap_m1;

  assign hp_m1  = (half_period == 8'd0) ? 8'd0 : half_period - 8'd1;
  assign gap_m1 = gap - 8'd1;
  assign led    = led_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q  <= S_ON;
      cnt_q <= '0;
      p_q   <= '0;
      led_q <= RstLed;
    end else begin
      st_q  <= st_n;
      cnt_q <= cnt_n;
      p_q   <= p_n;
      led_q <= led_n;
    end
  end

  // A restart takes priority over a coincident tick.
  always_comb begin
    st_n  = st_q;
    cnt_n = cnt_q;
    p_n   = p_q;
    led_n = led_q;
    if (restart) begin
      st_n  = S_ON;
      cnt_n = '0;
      p_n   = '0;
      led_n = (w_mode == MODE_ON) || (w_mode == MODE_BLINK) ||
              ((w_mode == MODE_BURST) && (w_burst_count != 8'd0));
    end else if (tick) begin
      case (mode)
        MODE_OFF: led_n = 1'b0;
        MODE_ON:  led_n = 1'b1;
        MODE_BLINK: begin
          if (cnt_q == hp_m1) begin
            led_n = ~led_q;
            cnt_n = '0;
          end else begin
            cnt_n = cnt_q + 8'd1;
          end
        end
        default: begin
          if (burst_count == 8'd0) begin
            led_n = 1'b0;
          end else begin
            case (st_q)
              S_ON: begin
                if (cnt_q == hp_m1) begin
                  cnt_n = '0;
                  st_n  = S_OFF;
                  led_n = 1'b0;
                end else begin
                  cnt_n = cnt_q + 8'd1;
                end
              end
              S_OFF: begin
                if (cnt_q == hp_m1) begin
                  cnt_n = '0;
                  if ((p_q + 8'd1) != burst_count) begin
                    p_n   = p_q + 8'd1;
                    st_n  = S_ON;
                    led_n = 1'b1;
                  end else if (gap == 8'd0) begin
                    p_n   = '0;
                    st_n  = S_ON;
                    led_n = 1'b1;
                  end else begin
                    p_n   = p_q + 8'd1;
                    st_n  = S_GAP;
                    led_n = 1'b0;
                  end
                end else begin
                  cnt_n = cnt_q + 8'd1;
                end
              end
              default: begin
                if (cnt_q == gap_m1) begin
                  cnt_n = '0;
                  p_n   = '0;
                  st_n  = S_ON;
                  led_n = 1'b1;
                end else begin
                  cnt_n = cnt_q + 8'd1;
                end
              end
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/led_blink_ctrl.sv
// LED sequencer top: shared prescaler tick, per-channel config registers
// with registered readback, and one led_channel per LED.
module led_blink_ctrl
  import led_pkg::*;
#(
  parameter int NumLeds      = NumLedsDef,
  parameter int PrescW       = PrescWDef,
  parameter int PrescReset   = PrescResetDef,
  parameter int HbHalfPeriod = HbHalfPeriodDef
) (
  input  logic               clk,
  input  logic               reset,
  led_blink_ctrl_if.slave    bus,
  output logic               tick,
  output logic [NumLeds-1:0] led
);

  localparam int AddrW = $clog2(NumLeds + 1);
  localparam LedCfgT RstCfg0 = '{gap: 8'd0, burst_count: 8'd0,
                                 half_period: 8'(HbHalfPeriod),
                                 rsvd: 6'd0, mode: MODE_BLINK};

  logic [PrescW-1:0]  presc_q;
  logic [PrescW-1:0]  pcnt;
  LedCfgT             cfg_q [NumLeds];
  LedCfgT             wcfg;
  logic [NumLeds-1:0] wr_ch;
  logic               presc_wr;
  logic [31:0]        rdata_n;

  assign wcfg     = cfg_from_word(bus.cfg_wdata);
  assign presc_wr = bus.cfg_we && (bus.cfg_addr == AddrW'(NumLeds));

  // A divisor write restarts the count and swallows any tick due this edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q <= PrescW'(PrescReset);
      pcnt    <= '0;
      tick    <= 1'b0;
    end else if (presc_wr) begin
      presc_q <= bus.cfg_wdata[PrescW-1:0];
      pcnt    <= '0;
      tick    <= 1'b0;
    end else if (pcnt == presc_q) begin
      pcnt <= '0;
      tick <= 1'b1;
    end else begin
      pcnt <= pcnt + 1'b1;
      tick <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NumLeds; i++) begin
      if (reset) begin
        if (i == 0) cfg_q[i] <= RstCfg0;
        else        cfg_q[i] <= '0;
      end else if (wr_ch[i]) begin
        cfg_q[i] <= wcfg;
      end
    end
  end

  always_comb begin
    rdata_n = '0;
    if (bus.cfg_addr == AddrW'(NumLeds)) rdata_n = 32'(presc_q);
    for (int i = 0; i < NumLeds; i++) begin
      if (bus.cfg_addr == AddrW'(i)) rdata_n = cfg_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset)           bus.cfg_rdata <= '0;
    else if (bus.cfg_re) bus.cfg_rdata <= rdata_n;
  end

  for (genvar i = 0; i < NumLeds; i++) begin : g_ch
    assign wr_ch[i] = bus.cfg_we && (bus.cfg_addr == AddrW'(i));

    led_channel #(
      .RstLed(i == 0)
    ) u_ch (
      .clk          (clk),
      .reset        (reset),
      .tick         (tick),
      .restart      (wr_ch[i]),
      .mode         (cfg_q[i].mode),
      .half_period  (cfg_q[i].half_period),
      .burst_count  (cfg_q[i].burst_count),
      .gap          (cfg_q[i].gap),
      .w_mode       (wcfg.mode),
      .w_burst_count(wcfg.burst_count),
      .led          (led[i])
    );
  end

endmodule
